// File: rtl/if_fetch_queue.sv
// Fetch front end: sequential ICache reads into a QUEUE_DEPTH FIFO, drained to IF/ID via inst_valid/inst_ready.
// Latency done->inst_valid is 1 cycle, or 0 when IFQ_BYPASS_EN is defined; fetch pauses while queue+inflight is full.
module if_fetch_queue #(
  parameter int                ADDR_W      = 32,
  parameter int                INST_W      = 32,
  parameter int                QUEUE_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [1:0]        rw_flag,
  output logic [ADDR_W-1:0] addr,
  output logic [INST_W-1:0] write_data,
  output logic [3:0]        write_mask,
  input  logic [INST_W-1:0] read_data,
  input  logic              icache_busy,
  input  logic              icache_done,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic              stall_req
);

  localparam int PTR_W   = $clog2(QUEUE_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int PC_STEP = INST_W / 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [INST_W-1:0]  mem_inst_q [QUEUE_DEPTH];
  logic [ADDR_W-1:0]  mem_pc_q   [QUEUE_DEPTH];

  logic head_vld;
  logic inflight;
  logic resp_take;
  logic bypass_vld;
  logic push;
  logic pop;
  logic space_now;
  logic space_after;

  assign head_vld  = (count_q != '0);
  assign inflight  = (state_q == S_WAIT) || (state_q == S_DISCARD);
  assign resp_take = icache_done && (state_q == S_WAIT);

`ifdef IFQ_BYPASS_EN
  assign bypass_vld = resp_take && !redirect_valid && !head_vld;
`else
  assign bypass_vld = 1'b0;
`endif

  // A bypassed word taken by the consumer never enters the queue.
  assign push = resp_take && !redirect_valid && !(bypass_vld && inst_ready);
  assign pop  = head_vld && inst_ready && !redirect_valid;

  // Queue pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign space_now   = (count_q + CNT_W'(inflight)) < CNT_W'(QUEUE_DEPTH);
  assign space_after = count_d < CNT_W'(QUEUE_DEPTH);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        mem_inst_q[i] <= '0;
        mem_pc_q[i]   <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) begin
        mem_inst_q[wr_ptr_q] <= read_data;
        mem_pc_q[wr_ptr_q]   <= fetch_pc_q;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      // A response landing in the redirect cycle is simply dropped, nothing stays outstanding.
      unique case (state_q)
        S_WAIT:    state_d = icache_done ? S_REQ : S_DISCARD;
        S_DISCARD: state_d = icache_done ? S_REQ : S_DISCARD;
        S_REQ:     state_d = icache_busy ? S_REQ : S_DISCARD;
        default:   state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (space_now) state_d = S_REQ;
        end
        S_REQ: begin
          if (!icache_busy) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (icache_done) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
            state_d    = space_after ? S_REQ : S_IDLE;
          end
        end
        default: begin
          if (icache_done) state_d = space_after ? S_REQ : S_IDLE;
        end
      endcase
    end
  end

  // FSM outputs
  always_comb begin
    rw_flag = {1'b0, (state_q == S_REQ)};
    addr    = fetch_pc_q;
  end

  assign write_data = '0;
  assign write_mask = '0;

  always_comb begin
    inst_valid = head_vld || bypass_vld;
    inst       = '0;
    inst_pc    = '0;
    if (bypass_vld) begin
      inst    = read_data;
      inst_pc = fetch_pc_q;
    end else if (head_vld) begin
      inst    = mem_inst_q[rd_ptr_q];
      inst_pc = mem_pc_q[rd_ptr_q];
    end
  end

  assign stall_req = !inst_valid;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: a per-cycle vector table, then responder-driven sequences
// for queue fill, refill after pop, redirect with a full queue, and done->inst_valid latency.
module tb_if_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  rw_flag;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [3:0]  write_mask;
  logic [31:0] read_data;
  logic        icache_busy;
  logic        icache_done;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        stall_req;

  always #5 clk = ~clk;

  if_fetch_queue dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .rw_flag        (rw_flag),
    .addr           (addr),
    .write_data     (write_data),
    .write_mask     (write_mask),
    .read_data      (read_data),
    .icache_busy    (icache_busy),
    .icache_done    (icache_done),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .stall_req      (stall_req)
  );

  localparam logic [31:0] MAGIC = 32'hC0DE_0000;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rv;
    logic [31:0] rpc;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        ready;
    logic [1:0]  rw;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] inst;
    logic [31:0] pc;
  } vec_t;

  function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic busy,
                              input logic done, input logic [31:0] rdata, input logic ready,
                              input logic [1:0] rw, input logic [31:0] a, input logic vld,
                              input logic [31:0] ins, input logic [31:0] pc);
    vec_t v;
    v.rv = rv; v.rpc = rpc; v.busy = busy; v.done = done; v.rdata = rdata; v.ready = ready;
    v.rw = rw; v.addr = a; v.vld = vld; v.inst = ins; v.pc = pc;
    return v;
  endfunction

  vec_t tbl[22];

  // ICache responder state: done two cycles after each accepted request, data = addr ^ MAGIC.
  int          cd;
  logic [31:0] paddr;
  int          cyc;
  int          done_cyc;
  int          accepts;
  logic [31:0] acc_q[$];
  logic        s_valid;
  logic        s_stall;
  logic [31:0] s_pc;
  logic [31:0] s_inst;
  logic [31:0] s_addr;
  logic [1:0]  s_rw;

  task automatic reset_dut();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    read_data      = '0;
    icache_busy    = 1'b0;
    icache_done    = 1'b0;
    inst_ready     = 1'b0;
    cd             = 0;
    cyc            = 0;
    done_cyc       = -100;
    accepts        = 0;
    acc_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic rcycle();
    icache_done = 1'b0;
    icache_busy = 1'b0;
    read_data   = '0;
    if (cd != 0) begin
      cd--;
      if (cd == 0) begin
        icache_done = 1'b1;
        read_data   = paddr ^ MAGIC;
        done_cyc    = cyc;
      end
    end
    @(negedge clk);
    s_valid = inst_valid;
    s_stall = stall_req;
    s_pc    = inst_pc;
    s_inst  = inst;
    s_addr  = addr;
    s_rw    = rw_flag;
    if (rw_flag == 2'b01 && !icache_busy) begin
      accepts++;
      acc_q.push_back(addr);
      cd    = 2;
      paddr = addr;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rw_late;
    int vcyc;
    logic [31:0] exp_a;

    //             rv  rpc        bsy done rdata          rdy   rw    addr       vld inst           pc
    tbl[0]  = mk(0, 32'h0,   0, 0, 32'h0,          1,  2'b00, 32'h000, 0, 32'h0,          32'h0);
    tbl[1]  = mk(0, 32'h0,   0, 0, 32'h0,          1,  2'b01, 32'h000, 0, 32'h0,          32'h0);
    tbl[2]  = mk(0, 32'h0,   0, 0, 32'h0,          1,  2'b00, 32'h000, 0, 32'h0,          32'h0);
    tbl[3]  = mk(0, 32'h0,   0, 1, 32'h1111_0000,  1,  2'b00, 32'h000, 0, 32'h0,          32'h0);
    tbl[4]  = mk(0, 32'h0,   0, 0, 32'h0,          1,  2'b01, 32'h004, 1, 32'h1111_0000,  32'h000);
    tbl[5]  = mk(0, 32'h0,   0, 0, 32'h0,          1,  2'b00, 32'h004, 0, 32'h0,          32'h0);
    tbl[6]  = mk(0, 32'h0,   0, 1, 32'h2222_0004,  1,  2'b00, 32'h004, 0, 32'h0,          32'h0);
    tbl[7]  = mk(0, 32'h0,   0, 0, 32'h0,          1,  2'b01, 32'h008, 1, 32'h2222_0004,  32'h004);
    tbl[8]  = mk(1, 32'h100, 0, 0, 32'h0,          1,  2'b00, 32'h008, 0, 32'h0,          32'h0);
    tbl[9]  = mk(0, 32'h0,   0, 1, 32'hDEAD_BEEF,  1,  2'b00, 32'h100, 0, 32'h0,          32'h0);
    tbl[10] = mk(0, 32'h0,   0, 0, 32'h0,          1,  2'b01, 32'h100, 0, 32'h0,          32'h0);
    tbl[11] = mk(0, 32'h0,   0, 0, 32'h0,          1,  2'b00, 32'h100, 0, 32'h0,          32'h0);
    tbl[12] = mk(0, 32'h0,   0, 1, 32'h3333_0100,  1,  2'b00, 32'h100, 0, 32'h0,          32'h0);
    tbl[13] = mk(0, 32'h0,   1, 0, 32'h0,          0,  2'b01, 32'h104, 1, 32'h3333_0100,  32'h100);
    tbl[14] = mk(0, 32'h0,   1, 0, 32'h0,          0,  2'b01, 32'h104, 1, 32'h3333_0100,  32'h100);
    tbl[15] = mk(0, 32'h0,   1, 0, 32'h0,          0,  2'b01, 32'h104, 1, 32'h3333_0100,  32'h100);
    tbl[16] = mk(0, 32'h0,   0, 0, 32'h0,          0,  2'b01, 32'h104, 1, 32'h3333_0100,  32'h100);
    tbl[17] = mk(0, 32'h0,   0, 0, 32'h0,          0,  2'b00, 32'h104, 1, 32'h3333_0100,  32'h100);
    tbl[18] = mk(0, 32'h0,   0, 1, 32'h4444_0104,  0,  2'b00, 32'h104, 1, 32'h3333_0100,  32'h100);
    tbl[19] = mk(0, 32'h0,   0, 0, 32'h0,          1,  2'b01, 32'h108, 1, 32'h3333_0100,  32'h100);
    tbl[20] = mk(0, 32'h0,   0, 0, 32'h0,          1,  2'b00, 32'h108, 1, 32'h4444_0104,  32'h104);
    tbl[21] = mk(0, 32'h0,   0, 0, 32'h0,          1,  2'b00, 32'h108, 0, 32'h0,          32'h0);

    // Reset values, sampled while reset is still asserted.
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    read_data      = '0;
    icache_busy    = 1'b0;
    icache_done    = 1'b0;
    inst_ready     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rw_flag", rw_flag, 2'b00);
    check("rst_addr", addr, 32'h0);
    check("rst_inst_valid", inst_valid, 1'b0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_stall_req", stall_req, 1'b1);
    check("rst_write_data", write_data, 32'h0);
    check("rst_write_mask", write_mask, 4'h0);
    rst = 1'b1;

    // Sequential fetch, redirect during WAIT, busy hold, push/pop overlap.
    for (int i = 0; i < 22; i++) begin
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      icache_busy    = tbl[i].busy;
      icache_done    = tbl[i].done;
      read_data      = tbl[i].rdata;
      inst_ready     = tbl[i].ready;
      @(negedge clk);
      check($sformatf("v%0d_rw_flag", i), rw_flag, tbl[i].rw);
      check($sformatf("v%0d_addr", i), addr, tbl[i].addr);
      check($sformatf("v%0d_inst_valid", i), inst_valid, tbl[i].vld);
      check($sformatf("v%0d_inst", i), inst, tbl[i].inst);
      check($sformatf("v%0d_inst_pc", i), inst_pc, tbl[i].pc);
      check($sformatf("v%0d_stall_req", i), stall_req, !tbl[i].vld);
      @(posedge clk);
      #1;
    end

    // Fill with inst_ready low: exactly QUEUE_DEPTH requests, then fetch stops.
    reset_dut();
    rw_late = 0;
    for (int i = 0; i < 24; i++) begin
      rcycle();
      if (i >= 16 && s_rw == 2'b01) rw_late++;
    end
    check("fill_accepts", accepts, 4);
    for (int i = 0; i < 4; i++) begin
      exp_a = 32'(i * 4);
      check($sformatf("fill_addr%0d", i), (acc_q.size() > i) ? acc_q[i] : 32'hFFFF_FFFF, exp_a);
    end
    check("fill_no_req_when_full", rw_late, 0);
    check("fill_head_valid", s_valid, 1'b1);
    check("fill_head_pc", s_pc, 32'h0);
    check("fill_head_inst", s_inst, MAGIC);

    // One pop reopens a slot and fetch resumes at 0x10.
    inst_ready = 1'b1;
    rcycle();
    check("pop_pc", s_pc, 32'h0);
    inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rcycle();
      if (accepts >= 5) break;
    end
    check("refill_accepts", accepts, 5);
    check("refill_addr", (acc_q.size() > 4) ? acc_q[4] : 32'hFFFF_FFFF, 32'h10);
    repeat (4) rcycle();
    check("refill_idle", s_rw, 2'b00);
    check("refill_head_pc", s_pc, 32'h4);

    // Redirect with a full queue and inst_ready high: flushed, nothing delivered from the old stream.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    inst_ready     = 1'b1;
    rcycle();
    check("rdr_cycle_head_valid", s_valid, 1'b1);
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    rcycle();
    check("rdr_flush_valid", s_valid, 1'b0);
    check("rdr_flush_stall", s_stall, 1'b1);
    check("rdr_req_rw", s_rw, 2'b01);
    check("rdr_req_addr", s_addr, 32'h200);

    // Latency from icache_done to inst_valid with an empty queue.
    vcyc = -1;
    for (int i = 0; i < 10; i++) begin
      rcycle();
      if (s_valid) begin
        vcyc = cyc - 1;
        break;
      end
    end
`ifdef IFQ_BYPASS_EN
    check("lat_done_to_valid", 64'(vcyc - done_cyc), 64'(0));
`else
    check("lat_done_to_valid", 64'(vcyc - done_cyc), 64'(1));
`endif
    check("rdr_first_pc", s_pc, 32'h200);
    check("rdr_first_inst", s_inst, 32'h200 ^ MAGIC);
    s_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rcycle();
      if (s_valid) break;
    end
    check("rdr_second_valid", s_valid, 1'b1);
    check("rdr_second_pc", s_pc, 32'h204);
    check("rdr_second_inst", s_inst, 32'h204 ^ MAGIC);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
